// File: rtl/i2c_reg_ctrl_if.sv
// rtl/i2c_reg_ctrl_if.sv - I2C front-end strobes and register-file bus for i2c_reg_ctrl
// master: the controller's view; slave: the front-end/register-file side.
interface i2c_reg_ctrl_if #(
  parameter int ADDR_W = 4
);
  logic [7:0]        i2c_addr_rw;
  logic              i2c_addr_rw_valid_stb;
  logic [7:0]        i2c_data_rx;
  logic              i2c_data_rx_valid_stb;
  logic [7:0]        i2c_data_tx;
  logic              i2c_data_tx_loaded_stb;
  logic              i2c_error_stb;
  logic              stall;
  logic [ADDR_W-1:0] reg_addr;
  logic [7:0]        reg_wdata;
  logic              reg_wr_stb;
  logic              reg_rd_req;
  logic              reg_rd_ack;
  logic [7:0]        reg_rdata;
  logic [7:0]        err_cnt;
  logic [2:0]        debug_state;

  modport master (
    input  i2c_addr_rw, i2c_addr_rw_valid_stb, i2c_data_rx, i2c_data_rx_valid_stb,
    input  i2c_data_tx_loaded_stb, i2c_error_stb, reg_rd_ack, reg_rdata,
    output i2c_data_tx, stall, reg_addr, reg_wdata, reg_wr_stb, reg_rd_req,
    output err_cnt, debug_state
  );

  modport slave (
    output i2c_addr_rw, i2c_addr_rw_valid_stb, i2c_data_rx, i2c_data_rx_valid_stb,
    output i2c_data_tx_loaded_stb, i2c_error_stb, reg_rd_ack, reg_rdata,
    input  i2c_data_tx, stall, reg_addr, reg_wdata, reg_wr_stb, reg_rd_req,
    input  err_cnt, debug_state
  );
endinterface

// File: rtl/i2c_reg_ctrl.sv
// rtl/i2c_reg_ctrl.sv - pointer-protocol register access controller behind an I2C target
// Optional pointer auto-increment: I2C_REG_CTRL_AUTOINC_EN.
module i2c_reg_ctrl #(
  parameter logic [6:0] I2C_ADDRESS = 7'h42,
  parameter int         ADDR_W      = 4
) (
  input  logic              clk,
  input  logic              rst,
  i2c_reg_ctrl_if.master    bus
);

`ifdef I2C_REG_CTRL_AUTOINC_EN
  localparam logic [ADDR_W-1:0] PTR_STEP = ADDR_W'(1);
`else
  localparam logic [ADDR_W-1:0] PTR_STEP = '0;
`endif

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WPTR   = 3'd1,
    WDATA  = 3'd2,
    RFETCH = 3'd3,
    RREADY = 3'd4
  } state_t;

  state_t            state, state_d;
  logic [ADDR_W-1:0] ptr, ptr_d;
  logic [ADDR_W-1:0] addr_d;
  logic [7:0]        tx_d, wdata_d, err_d;
  logic              wr_d, fetch_d;

  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    tx_d    = bus.i2c_data_tx;
    wdata_d = bus.reg_wdata;
    err_d   = bus.err_cnt;
    wr_d    = 1'b0;

    if (bus.i2c_error_stb) begin
      state_d = IDLE;
      if (bus.err_cnt != 8'hFF) err_d = bus.err_cnt + 8'd1;
    end else if (bus.i2c_addr_rw_valid_stb) begin
      if (bus.i2c_addr_rw[7:1] != I2C_ADDRESS) state_d = IDLE;
      else if (bus.i2c_addr_rw[0])             state_d = RFETCH;
      else                                     state_d = WPTR;
    end else begin
      unique case (state)
        WPTR: if (bus.i2c_data_rx_valid_stb) begin
          ptr_d   = bus.i2c_data_rx[ADDR_W-1:0];
          state_d = WDATA;
        end
        WDATA: if (bus.i2c_data_rx_valid_stb) begin
          wr_d    = 1'b1;
          wdata_d = bus.i2c_data_rx;
          ptr_d   = ptr + PTR_STEP;
        end
        RFETCH: if (bus.reg_rd_ack && bus.reg_rd_req) begin
          tx_d    = bus.reg_rdata;
          state_d = RREADY;
        end
        RREADY: if (bus.i2c_data_tx_loaded_stb) begin
          ptr_d   = ptr + PTR_STEP;
          state_d = RFETCH;
        end
        default: ;
      endcase
    end

    // A write strobe must present the pre-increment pointer alongside its data.
    addr_d  = wr_d ? ptr : ptr_d;
    fetch_d = (state_d == RFETCH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      ptr             <= '0;
      bus.i2c_data_tx <= 8'h00;
      bus.stall       <= 1'b0;
      bus.reg_addr    <= '0;
      bus.reg_wdata   <= 8'h00;
      bus.reg_wr_stb  <= 1'b0;
      bus.reg_rd_req  <= 1'b0;
      bus.err_cnt     <= 8'h00;
    end else begin
      state           <= state_d;
      ptr             <= ptr_d;
      bus.i2c_data_tx <= tx_d;
      bus.stall       <= fetch_d;
      bus.reg_addr    <= addr_d;
      bus.reg_wdata   <= wdata_d;
      bus.reg_wr_stb  <= wr_d;
      bus.reg_rd_req  <= fetch_d;
      bus.err_cnt     <= err_d;
    end
  end

  assign bus.debug_state = state;

endmodule

// File: doc/i2c_reg_ctrl.md
# i2c_reg_ctrl

Register-access controller sitting between the I2C target front-end (`i2c_simple_slave` strobe interface) and an on-chip 8-bit register file. It implements the conventional pointer protocol:
- A write transaction's first data byte sets a register pointer; subsequent bytes write successive registers.
- A read transaction streams registers starting at the pointer.

It sequences the front-end's clock-stretch (`stall`) so TX data is always fetched before the front-end loads it.

## Interface
Parameters:
- `I2C_ADDRESS`, 7'h42, target address; must match the front-end's address.
- `ADDR_W`, 4, register pointer width; the register file has 2^ADDR_W entries.

Ports:
- `clk`  in  1  system clock. One clock domain; all ports sampled/driven on rising edge.
- `rst`  in  1  reset. Synchronous, active-high.
- `i2c_addr_rw`  in  8  address/RW byte from front-end; bit0=1 means read.
- `i2c_addr_rw_valid_stb`  in  1  one-cycle strobe; `i2c_addr_rw` is valid.
- `i2c_data_rx`  in  8  received data byte.
- `i2c_data_rx_valid_stb`  in  1  one-cycle strobe; `i2c_data_rx` is valid.
- `i2c_data_tx`  out  8  byte offered to front-end for transmission.
- `i2c_data_tx_loaded_stb`  in  1  front-end consumed `i2c_data_tx`.
- `i2c_error_stb`  in  1  front-end protocol error.
- `stall`  out  1  clock-stretch request to front-end.
- `reg_addr`  out  ADDR_W  register file address (equals pointer).
- `reg_wdata`  out  8  write data.
- `reg_wr_stb`  out  1  one-cycle write strobe.
- `reg_rd_req`  out  1  level read request; held until ack or abort.
- `reg_rd_ack`  in  1  one-cycle; `reg_rdata` valid this cycle.
- `reg_rdata`  in  8  read data.
- `err_cnt`  out  8  saturating count of `i2c_error_stb` events.
- `debug_state`  out  3  current FSM state encoding.

## Operation
- Address filter: an `i2c_addr_rw_valid_stb` with `i2c_addr_rw[7:1]` != `I2C_ADDRESS` forces IDLE and is otherwise ignored.
- States: IDLE=0, WPTR=1, WDATA=2, RFETCH=3, RREADY=4.
- Transitions from a matching address strobe (any state):
  - bit0=0 → WPTR.
  - bit0=1 → RFETCH.
- Any address strobe aborts a pending read: drop `reg_rd_req`; discard a later ack.
- WPTR, on rx strobe: pointer <= `i2c_data_rx[ADDR_W-1:0]` (upper bits ignored) → WDATA. No register write occurs.
- WDATA, on rx strobe:
  - `reg_wr_stb`=1 with `reg_addr`=pointer and `reg_wdata`=byte.
  - pointer += 1. Stay in WDATA.
- RFETCH:
  - `reg_rd_req`=1 and `stall`=1.
  - On `reg_rd_ack`: latch `reg_rdata` into `i2c_data_tx`; deassert req and stall → RREADY.
- RREADY, on `i2c_data_tx_loaded_stb`: pointer += 1 → RFETCH.
  - This prefetches the next byte, so a master NAK leaves one speculative read. Registers with read side effects must not be placed in a streamed range.
- Rx strobes in IDLE/RFETCH/RREADY and loaded strobes outside RREADY are ignored.
- Pointer arithmetic is modulo 2^ADDR_W: 2^ADDR_W−1 wraps to 0.
- The pointer persists across transactions and is cleared only by reset. This supports "W ptr, Sr, R data".
- `i2c_error_stb` → IDLE, drop req, stall=0, `err_cnt`+=1 saturating at 8'hFF. Pointer is unchanged.
- Priority in the same cycle: `rst` > `i2c_error_stb` > `i2c_addr_rw_valid_stb` > data/loaded/ack strobes.

## Timing
- All outputs are registered.
- Reset values:
  - state IDLE, pointer 0.
  - `i2c_data_tx`=0, `stall`=0.
  - `reg_addr`=0, `reg_wdata`=0, `reg_wr_stb`=0, `reg_rd_req`=0.
  - `err_cnt`=0.
- Write: rx strobe at cycle N → `reg_wr_stb` at N+1 with that byte and the old pointer. The incremented pointer shows on `reg_addr` at N+2.
- Read start: address strobe at N → `reg_rd_req`=`stall`=1 from N+1 with `reg_addr`=pointer.
- Ack at M → `i2c_data_tx` valid and `stall`=0 at M+1. Ack latency is unbounded; stall holds the bus meanwhile.
- Loaded strobe at K → `reg_addr`=pointer+1, `reg_rd_req`=`stall`=1 at K+1.
- An ack in the same cycle as the request is raised is impossible. An ack while `reg_rd_req`=0 is ignored.
- Reset mid-read drops req in the next cycle. The register file must tolerate a withdrawn request.

## Configuration
- `I2C_REG_CTRL_AUTOINC_EN`:
  - Defined: pointer increments after each write and each loaded TX byte, as above.
  - Undefined: pointer changes only in WPTR. Repeated writes/reads target the same register, and RFETCH re-reads the same address after each loaded strobe.

## Test plan
- Write burst: addr 0x84, rx 0x03, 0xAA, 0xBB → `reg_wr_stb` twice: (addr 3, 0xAA), (addr 4, 0xBB); no write for the pointer byte.
- Read with stall: addr 0x84 + rx 0x0F, then addr 0x85, ack after 20 cycles with 0x5C → `stall` high exactly 20 cycles; `i2c_data_tx`=0x5C. After loaded strobe, `reg_addr`=0 (wrap) with stall reasserted.
- Address mismatch: addr 0x90 then rx 0x11 → no `reg_wr_stb`, state IDLE, pointer unchanged.
- Error abort: error strobe in RFETCH together with `reg_rd_ack` → IDLE, `stall`=0, `i2c_data_tx` unchanged, `err_cnt`=1. Saturation check: 300 errors → `err_cnt`=8'hFF.
- Restart abort: read pending, new address 0x84 arrives → req drops next cycle; a later ack does not update `i2c_data_tx`.
- Macro off: write 0x84, 0x02, 0x10, 0x20 → both writes hit addr 2.
